// File: rtl/rv32i_dec_exe_mem_if.sv
// Datapath bundle between the PC/register-file side (master) and the
// decode/execute/memory slice (slave). Optional ebreak under EBREAK_DETECT_EN.
interface rv32i_dec_exe_mem_if;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        rf_wen;
  logic [31:0] rf_wdata;
  logic [31:0] npc;
  logic        illegal;
`ifdef EBREAK_DETECT_EN
  logic        ebreak;
`endif

  modport master (
`ifdef EBREAK_DETECT_EN
    input  ebreak,
`endif
    output inst, pc, rs1_data, rs2_data,
    input  rs1, rs2, rd, rf_wen, rf_wdata, npc, illegal
  );

  modport slave (
`ifdef EBREAK_DETECT_EN
    output ebreak,
`endif
    input  inst, pc, rs1_data, rs2_data,
    output rs1, rs2, rd, rf_wen, rf_wdata, npc, illegal
  );
endinterface

// File: rtl/rv32i_dec_exe_mem.sv
// Single-cycle RV32I decode/execute/data-memory slice with byte-enabled RAM.
// Optional EBREAK_DETECT_EN adds an ebreak flag for 32'h00100073.
module rv32i_dec_exe_mem #(
  parameter int DWIDTH     = 32,
  parameter int MEM_AWIDTH = 10
) (
  input logic                clk,
  input logic                rst,
  rv32i_dec_exe_mem_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [DWIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [DWIDTH-1:0] w_imm, w_a, w_b, w_alu, w_pc4;
  alu_op_e           w_alu_op;
  a_sel_e            w_a_sel;
  wb_sel_e           w_wb_sel;
  logic              w_b_imm, w_wb_en, w_illegal, w_ebreak;
  logic              w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
  logic              w_taken, w_store_en;

  assign w_opcode = bus.inst[6:0];
  assign w_f3     = bus.inst[14:12];
  assign w_f7     = bus.inst[31:25];
  assign bus.rs1  = bus.inst[19:15];
  assign bus.rs2  = bus.inst[24:20];
  assign bus.rd   = bus.inst[11:7];

  assign w_imm_i = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign w_imm_s = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
  assign w_imm_b = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                    bus.inst[30:25], bus.inst[11:8], 1'b0};
  assign w_imm_u = {bus.inst[31:12], 12'b0};
  assign w_imm_j = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                    bus.inst[20], bus.inst[30:21], 1'b0};

  always_comb begin
    w_alu_op    = ALU_ADD;
    w_a_sel     = A_RS1;
    w_b_imm     = 1'b0;
    w_imm       = w_imm_i;
    w_wb_sel    = WB_ALU;
    w_wb_en     = 1'b0;
    w_illegal   = 1'b0;
    w_ebreak    = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    unique case (w_opcode)
      OP_LUI: begin
        w_a_sel = A_ZERO; w_b_imm = 1'b1; w_imm = w_imm_u; w_wb_en = 1'b1;
      end
      OP_AUIPC: begin
        w_a_sel = A_PC; w_b_imm = 1'b1; w_imm = w_imm_u; w_wb_en = 1'b1;
      end
      OP_JAL: begin
        w_a_sel = A_PC; w_b_imm = 1'b1; w_imm = w_imm_j;
        w_wb_sel = WB_PC4; w_wb_en = 1'b1; w_is_jal = 1'b1;
      end
      OP_JALR: begin
        w_b_imm = 1'b1; w_wb_sel = WB_PC4; w_wb_en = 1'b1; w_is_jalr = 1'b1;
        w_illegal = (w_f3 != 3'b000);
      end
      OP_BRANCH: begin
        w_a_sel = A_PC; w_b_imm = 1'b1; w_imm = w_imm_b; w_is_branch = 1'b1;
        w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OP_LOAD: begin
        w_b_imm = 1'b1; w_wb_sel = WB_MEM; w_wb_en = 1'b1; w_is_load = 1'b1;
        w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OP_STORE: begin
        w_b_imm = 1'b1; w_imm = w_imm_s; w_is_store = 1'b1;
        w_illegal = (w_f3 > 3'b010);
      end
      OP_IMM, OP_REG: begin
        w_b_imm = (w_opcode == OP_IMM);
        w_wb_en = 1'b1;
        unique case (w_f3)
          3'b000: w_alu_op = (w_opcode == OP_REG && w_f7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: w_alu_op = ALU_SLL;
          3'b010: w_alu_op = ALU_SLT;
          3'b011: w_alu_op = ALU_SLTU;
          3'b100: w_alu_op = ALU_XOR;
          3'b101: w_alu_op = w_f7[5] ? ALU_SRA : ALU_SRL;
          3'b110: w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
        // funct7 only constrains shifts for OP-IMM, every encoding for OP
        if (w_opcode == OP_REG || w_f3 == 3'b001 || w_f3 == 3'b101) begin
          if (w_f7 == 7'b0100000)
            w_illegal = !((w_f3 == 3'b101) || (w_opcode == OP_REG && w_f3 == 3'b000));
          else
            w_illegal = (w_f7 != 7'b0000000);
        end
      end
      default: begin
`ifdef EBREAK_DETECT_EN
        if (bus.inst == 32'h0010_0073) w_ebreak = 1'b1;
        else                           w_illegal = 1'b1;
`else
        w_illegal = 1'b1;
`endif
      end
    endcase
  end

`ifdef EBREAK_DETECT_EN
  assign bus.ebreak = w_ebreak;
`endif

  always_comb begin
    unique case (w_a_sel)
      A_PC:    w_a = bus.pc;
      A_ZERO:  w_a = '0;
      default: w_a = bus.rs1_data;
    endcase
  end

  assign w_b   = w_b_imm ? w_imm : bus.rs2_data;
  assign w_pc4 = bus.pc + 32'd4;

  always_comb begin
    unique case (w_alu_op)
      ALU_SUB:  w_alu = w_a - w_b;
      ALU_AND:  w_alu = w_a & w_b;
      ALU_OR:   w_alu = w_a | w_b;
      ALU_XOR:  w_alu = w_a ^ w_b;
      ALU_SLL:  w_alu = w_a << w_b[4:0];
      ALU_SRL:  w_alu = w_a >> w_b[4:0];
      ALU_SRA:  w_alu = $signed(w_a) >>> w_b[4:0];
      ALU_SLT:  w_alu = {31'b0, $signed(w_a) < $signed(w_b)};
      ALU_SLTU: w_alu = {31'b0, w_a < w_b};
      default:  w_alu = w_a + w_b;
    endcase
  end

  always_comb begin
    unique case (w_f3)
      3'b000:  w_taken = (bus.rs1_data == bus.rs2_data);
      3'b001:  w_taken = (bus.rs1_data != bus.rs2_data);
      3'b100:  w_taken = ($signed(bus.rs1_data) < $signed(bus.rs2_data));
      3'b101:  w_taken = !($signed(bus.rs1_data) < $signed(bus.rs2_data));
      3'b110:  w_taken = (bus.rs1_data < bus.rs2_data);
      3'b111:  w_taken = !(bus.rs1_data < bus.rs2_data);
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    bus.npc = w_pc4;
    if (!w_illegal) begin
      if (w_is_jal || (w_is_branch && w_taken)) bus.npc = w_alu;
      else if (w_is_jalr)                       bus.npc = {w_alu[31:1], 1'b0};
    end
  end

  // Data RAM: address is the ALU sum; bits above the RAM index alias
  logic [DWIDTH-1:0]     r_mem [0:(1<<MEM_AWIDTH)-1];
  logic [MEM_AWIDTH-1:0] w_idx;
  logic [1:0]            w_off;
  logic [DWIDTH-1:0]     w_rword, w_load, w_sdat;
  logic [3:0]            w_wbe;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_idx   = w_alu[MEM_AWIDTH+1:2];
  assign w_off   = w_alu[1:0];
  assign w_rword = r_mem[w_idx];
  assign w_half  = w_off[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    unique case (w_off)
      2'd0:    w_byte = w_rword[7:0];
      2'd1:    w_byte = w_rword[15:8];
      2'd2:    w_byte = w_rword[23:16];
      default: w_byte = w_rword[31:24];
    endcase
  end

  always_comb begin
    unique case (w_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'b0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = w_rword;
    endcase
  end

  always_comb begin
    unique case (w_f3)
      3'b000: begin
        w_wbe  = 4'b0001 << w_off;
        w_sdat = bus.rs2_data << {w_off, 3'b000};
      end
      3'b001: begin
        w_wbe  = w_off[1] ? 4'b1100 : 4'b0011;
        w_sdat = bus.rs2_data << {w_off[1], 4'b0000};
      end
      default: begin
        w_wbe  = '1;
        w_sdat = bus.rs2_data;
      end
    endcase
  end

  assign w_store_en = rst && w_is_store && !w_illegal;

  // Read path is combinational, so a write this edge is seen by the next instruction only
  always_ff @(posedge clk) begin
    if (w_store_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_wbe[b]) r_mem[w_idx][8*b +: 8] <= w_sdat[8*b +: 8];
      end
    end
  end

  always_comb begin
    unique case (w_wb_sel)
      WB_MEM:  bus.rf_wdata = w_load;
      WB_PC4:  bus.rf_wdata = w_pc4;
      default: bus.rf_wdata = w_alu;
    endcase
  end

  assign bus.rf_wen  = rst && w_wb_en && !w_illegal && (bus.inst[11:7] != 5'd0);
  assign bus.illegal = w_illegal;

endmodule

// File: tb/tb_rv32i_dec_exe_mem.sv
// Table-driven scoreboard bench for rv32i_dec_exe_mem, vectors applied in order
// so stores feed later loads; EBREAK_DETECT_EN selects the ebreak expectation.
module tb_rv32i_dec_exe_mem;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rv32i_dec_exe_mem_if bus ();

  rv32i_dec_exe_mem #(.DWIDTH(32), .MEM_AWIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic        rst;
    logic        wen;
    logic [4:0]  rd;
    logic        chk_wdata;
    logic [31:0] wdata;
    logic [31:0] npc;
    logic        illegal;
  } vec_t;

  typedef struct {
    string       name;
    logic        wen;
    logic [4:0]  rd;
    logic        chk_wdata;
    logic [31:0] wdata;
    logic [31:0] npc;
    logic        illegal;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [31:0] inst, input logic [31:0] pc,
                     input logic [31:0] r1, input logic [31:0] r2, input logic rs,
                     input logic wen, input logic [4:0] rd, input logic cw,
                     input logic [31:0] wd, input logic [31:0] np, input logic ill);
    vec_t v;
    v.name = n; v.inst = inst; v.pc = pc; v.rs1d = r1; v.rs2d = r2; v.rst = rs;
    v.wen = wen; v.rd = rd; v.chk_wdata = cw; v.wdata = wd; v.npc = np; v.illegal = ill;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    bus.inst = v.inst; bus.pc = v.pc; bus.rs1_data = v.rs1d; bus.rs2_data = v.rs2d;
    rst = v.rst;
    e.name = v.name; e.wen = v.wen; e.rd = v.rd; e.chk_wdata = v.chk_wdata;
    e.wdata = v.wdata; e.npc = v.npc; e.illegal = v.illegal;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard: got empty queue expected one entry");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".wen"}, {31'b0, bus.rf_wen}, {31'b0, e.wen});
    chk({e.name, ".rd"}, {27'b0, bus.rd}, {27'b0, e.rd});
    chk({e.name, ".npc"}, bus.npc, e.npc);
    chk({e.name, ".illegal"}, {31'b0, bus.illegal}, {31'b0, e.illegal});
    if (e.chk_wdata) chk({e.name, ".wdata"}, bus.rf_wdata, e.wdata);
  endtask

  initial begin
    bus.inst = 32'h0000_0013; bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0;

    //   name            inst          pc            rs1         rs2         rst  wen rd cw wdata          npc           ill
    add("reset_addi",   32'hFFF00093, 32'h0000_0000, 32'h0,       32'h0,       0, 0, 1, 1, 32'hFFFF_FFFF, 32'h0000_0004, 0);
    add("addi_m1",      32'hFFF00093, 32'h0000_0040, 32'h0,       32'h0,       1, 1, 1, 1, 32'hFFFF_FFFF, 32'h0000_0044, 0);
    add("lui",          32'h12345137, 32'h8000_0000, 32'h0,       32'h0,       1, 1, 2, 1, 32'h1234_5000, 32'h8000_0004, 0);
    add("auipc",        32'h00001197, 32'h8000_0000, 32'h0,       32'h0,       1, 1, 3, 1, 32'h8000_1000, 32'h8000_0004, 0);
    add("addi_x0",      32'h00500013, 32'h0000_0000, 32'h0,       32'h0,       1, 0, 0, 1, 32'h0000_0005, 32'h0000_0004, 0);
    add("sub",          32'h402081B3, 32'h0000_0000, 32'h5,       32'h7,       1, 1, 3, 1, 32'hFFFF_FFFE, 32'h0000_0004, 0);
    add("sra",          32'h4020D1B3, 32'h0000_0000, 32'h8000_0000, 32'h4,     1, 1, 3, 1, 32'hF800_0000, 32'h0000_0004, 0);
    add("sltu",         32'h0020B1B3, 32'h0000_0000, 32'h1,       32'hFFFF_FFFF, 1, 1, 3, 1, 32'h0000_0001, 32'h0000_0004, 0);
    add("slt",          32'h0020A1B3, 32'h0000_0000, 32'h1,       32'hFFFF_FFFF, 1, 1, 3, 1, 32'h0000_0000, 32'h0000_0004, 0);
    add("sw",           32'h0020A023, 32'h0000_0000, 32'h10,      32'hA1B2_C3D4, 1, 0, 0, 0, 32'h0,        32'h0000_0004, 0);
    add("lb",           32'h00008283, 32'h0000_0000, 32'h11,      32'h0,       1, 1, 5, 1, 32'hFFFF_FFC3, 32'h0000_0004, 0);
    add("lbu",          32'h0000C283, 32'h0000_0000, 32'h11,      32'h0,       1, 1, 5, 1, 32'h0000_00C3, 32'h0000_0004, 0);
    add("lh",           32'h00009283, 32'h0000_0000, 32'h12,      32'h0,       1, 1, 5, 1, 32'hFFFF_A1B2, 32'h0000_0004, 0);
    add("lhu",          32'h0000D283, 32'h0000_0000, 32'h12,      32'h0,       1, 1, 5, 1, 32'h0000_A1B2, 32'h0000_0004, 0);
    add("lw",           32'h0000A283, 32'h0000_0000, 32'h10,      32'h0,       1, 1, 5, 1, 32'hA1B2_C3D4, 32'h0000_0004, 0);
    add("sb",           32'h00208023, 32'h0000_0000, 32'h13,      32'h55,      1, 0, 0, 0, 32'h0,        32'h0000_0004, 0);
    add("lw_after_sb",  32'h0000A283, 32'h0000_0000, 32'h10,      32'h0,       1, 1, 5, 1, 32'h55B2_C3D4, 32'h0000_0004, 0);
    add("sw_in_reset",  32'h0020A023, 32'h0000_0000, 32'h10,      32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0,      32'h0000_0004, 0);
    add("lw_kept",      32'h0000A283, 32'h0000_0000, 32'h10,      32'h0,       1, 1, 5, 1, 32'h55B2_C3D4, 32'h0000_0004, 0);
    add("lw_alias",     32'h0000A283, 32'h0000_0000, 32'h1010,    32'h0,       1, 1, 5, 1, 32'h55B2_C3D4, 32'h0000_0004, 0);
    add("blt_taken",    32'h0020C463, 32'h0000_0100, 32'hFFFF_FFFF, 32'h1,     1, 0, 8, 0, 32'h0,        32'h0000_0108, 0);
    add("bltu_not",     32'h0020E463, 32'h0000_0100, 32'hFFFF_FFFF, 32'h1,     1, 0, 8, 0, 32'h0,        32'h0000_0104, 0);
    add("bge_not",      32'h0020D463, 32'h0000_0100, 32'hFFFF_FFFF, 32'h1,     1, 0, 8, 0, 32'h0,        32'h0000_0104, 0);
    add("bgeu_taken",   32'h0020F463, 32'h0000_0100, 32'hFFFF_FFFF, 32'h1,     1, 0, 8, 0, 32'h0,        32'h0000_0108, 0);
    add("bne_not",      32'h00209463, 32'h0000_0100, 32'h5,       32'h5,       1, 0, 8, 0, 32'h0,        32'h0000_0104, 0);
    add("beq_taken",    32'h00208463, 32'h0000_0100, 32'h5,       32'h5,       1, 0, 8, 0, 32'h0,        32'h0000_0108, 0);
    add("jalr",         32'h004080E7, 32'h0000_0300, 32'h201,     32'h0,       1, 1, 1, 1, 32'h0000_0304, 32'h0000_0204, 0);
    add("jal_fwd",      32'h010000EF, 32'h0000_0200, 32'h0,       32'h0,       1, 1, 1, 1, 32'h0000_0204, 32'h0000_0210, 0);
    add("jal_back",     32'hFFDFF0EF, 32'h0000_0200, 32'h0,       32'h0,       1, 1, 1, 1, 32'h0000_0204, 32'h0000_01FC, 0);
    add("bad_opcode",   32'h000000FF, 32'h0000_0100, 32'h0,       32'h0,       1, 0, 1, 0, 32'h0,        32'h0000_0104, 1);
    add("bad_funct7",   32'h022081B3, 32'h0000_0100, 32'h0,       32'h0,       1, 0, 3, 0, 32'h0,        32'h0000_0104, 1);
`ifdef EBREAK_DETECT_EN
    add("ebreak",       32'h00100073, 32'h0000_0100, 32'h0,       32'h0,       1, 0, 0, 0, 32'h0,        32'h0000_0104, 0);
`else
    add("ebreak",       32'h00100073, 32'h0000_0100, 32'h0,       32'h0,       1, 0, 0, 0, 32'h0,        32'h0000_0104, 1);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check_out();
      if (vecs[i].name == "sw") begin
        chk("sw.rs1", {27'b0, bus.rs1}, 32'd1);
        chk("sw.rs2", {27'b0, bus.rs2}, 32'd2);
      end
`ifdef EBREAK_DETECT_EN
      if (vecs[i].name == "ebreak") chk("ebreak.flag", {31'b0, bus.ebreak}, 32'd1);
      if (vecs[i].name == "lw")     chk("ebreak.quiet", {31'b0, bus.ebreak}, 32'd0);
`endif
    end

    // Reset dropped mid-cycle while a store is presented: write blocked, wen falls at once
    @(negedge clk);
    bus.inst = 32'h0020A023; bus.rs1_data = 32'h10; bus.rs2_data = 32'h1234_5678; rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    bus.inst = 32'hFFF00093;
    #1 chk("async_rst.wen", {31'b0, bus.rf_wen}, 32'd0);
    rst = 1'b1;
    #1 chk("async_rst.wen_back", {31'b0, bus.rf_wen}, 32'd1);
    bus.inst = 32'h0000A283; bus.rs1_data = 32'h10;
    #1 chk("async_rst.ram_kept", bus.rf_wdata, 32'h55B2_C3D4);

    // Store then load: the load issued before the edge sees old data, after sees new
    @(negedge clk);
    bus.inst = 32'h0020A023; bus.rs1_data = 32'h20; bus.rs2_data = 32'h0BAD_F00D;
    @(negedge clk);
    bus.inst = 32'h0020A023; bus.rs1_data = 32'h20; bus.rs2_data = 32'h600D_CAFE;
    #1 bus.inst = 32'h0000A283;
    #1 chk("ld_st.old", bus.rf_wdata, 32'h0BAD_F00D);
    bus.inst = 32'h0020A023;
    @(negedge clk);
    bus.inst = 32'h0000A283;
    #1 chk("ld_st.new", bus.rf_wdata, 32'h600D_CAFE);

    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
